// File: rtl/imem_loader.sv
// Serial program loader: assembles big-endian bytes into 32-bit words and writes them to imem.
// Optional trailing-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned IMEM_SIZE = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] WORD_COUNT,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        WE,
  output logic [31:0] W_Ins,
  output logic [31:0] PC,
  output logic        HOLD,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StWrite   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCheck   = 3'd3,
`endif
    StFinish  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] word_count_q, word_count_d;
  logic [31:0] w_ins_q, w_ins_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        byte_ok;
  logic [31:0] w_shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  // CHECK reuses the word shifter to assemble the checksum word.
  assign w_shift = {w_ins_q[23:0], BYTE_IN};
  assign byte_ok = BYTE_VALID && BYTE_READY;

  always_comb begin
    BYTE_READY = 1'b0;
    HOLD       = 1'b0;
    WE         = 1'b0;
    unique case (state_q)
      StCollect: begin
        BYTE_READY = 1'b1;
        HOLD       = 1'b1;
      end
      StWrite: begin
        WE   = 1'b1;
        HOLD = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        BYTE_READY = 1'b1;
        HOLD       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign W_Ins = w_ins_q;
  assign PC    = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
  assign DONE  = done_q;
  assign ERR   = err_q;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    w_ins_d      = w_ins_q;
    done_d       = done_q;
    err_d        = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    unique case (state_q)
      StIdle, StFinish: begin
        if (START) begin
          word_idx_d   = 16'd0;
          byte_idx_d   = 2'd0;
          word_count_d = WORD_COUNT;
          done_d       = 1'b0;
          err_d        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d        = 32'd0;
`endif
          if (WORD_COUNT == 16'd0) begin
            state_d = StFinish;
            done_d  = 1'b1;
          end else if ({16'd0, WORD_COUNT} > IMEM_SIZE) begin
            state_d = StFinish;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (byte_ok) begin
          w_ins_d    = w_shift;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q + w_ins_q;
`endif
        if (word_idx_d == word_count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StFinish;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = StCollect;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (byte_ok) begin
          w_ins_d    = w_shift;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            err_d   = (w_shift != sum_q);
            done_d  = 1'b1;
            state_d = StFinish;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= 16'd0;
      word_count_q <= 16'd0;
      w_ins_q      <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      w_ins_q      <= w_ins_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, size limits, byte gaps, START-ignore, mid-load reset,
// and (with IMEM_LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        CLK, RST, START, BYTE_VALID;
  logic [15:0] WORD_COUNT;
  logic [7:0]  BYTE_IN;
  logic        BYTE_READY, WE, HOLD, DONE, ERR;
  logic [31:0] W_Ins, PC;

  int total, bad, cyc;
  logic [31:0] wr_pc[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  bit          hold_seen;

  imem_loader #(.IMEM_SIZE(256), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .START(START), .WORD_COUNT(WORD_COUNT), .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY), .WE(WE), .W_Ins(W_Ins), .PC(PC),
    .HOLD(HOLD), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write log, sampled mid-cycle.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (WE === 1'b1) begin
      wr_pc.push_back(PC);
      wr_data.push_back(W_Ins);
      wr_cyc.push_back(cyc);
    end
    if (HOLD === 1'b1) hold_seen = 1'b1;
  end

  task automatic clear_log();
    wr_pc.delete();
    wr_data.delete();
    wr_cyc.delete();
    hold_seen = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] c);
    START = 1'b1;
    WORD_COUNT = c;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit got;
    got = 1'b0;
    BYTE_VALID = 1'b1;
    BYTE_IN = b;
    for (int k = 0; k < 40; k++) begin
      if (BYTE_READY === 1'b1) begin
        got = 1'b1;
        @(negedge CLK);
        break;
      end
      @(negedge CLK);
    end
    total++;
    if (!got) begin bad++; $display("FAIL byte_accept: byte %h got no ready, want ready", b); end
    if (gap) begin
      BYTE_VALID = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (DONE === 1'b1) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL wait_done: DONE got %b want 1 (timeout)", DONE); end
  endtask

  task automatic test_reset();
    total++; if (BYTE_READY !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", BYTE_READY); end
    total++; if (WE !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", WE); end
    total++; if (W_Ins !== 32'h0) begin bad++; $display("FAIL rst_wins: got %h want 0", W_Ins); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", PC); end
    total++; if (HOLD !== 1'b0) begin bad++; $display("FAIL rst_hold: got %b want 0", HOLD); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", DONE); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", ERR); end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start(16'd2);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h0000_0008, 1'b0);
    BYTE_VALID = 1'b0;
    if (ChkEn) send_word(32'h2008_000D, 1'b0);
    BYTE_VALID = 1'b0;
    wait_done();
    total++; if (wr_pc.size() !== 2) begin bad++; $display("FAIL basic_nwr: got %0d want 2", wr_pc.size()); end
    total++; if (wr_pc[0] !== 32'h0) begin bad++; $display("FAIL basic_pc0: got %h want 0", wr_pc[0]); end
    total++; if (wr_data[0] !== 32'h2008_0005) begin bad++; $display("FAIL basic_w0: got %h want 20080005", wr_data[0]); end
    total++; if (wr_pc[1] !== 32'h4) begin bad++; $display("FAIL basic_pc1: got %h want 4", wr_pc[1]); end
    total++; if (wr_data[1] !== 32'h0000_0008) begin bad++; $display("FAIL basic_w1: got %h want 00000008", wr_data[1]); end
    total++; if (wr_cyc[1] - wr_cyc[0] !== 5) begin bad++; $display("FAIL basic_rate: got %0d want 5", wr_cyc[1] - wr_cyc[0]); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", ERR); end
    total++; if (HOLD !== 1'b0) begin bad++; $display("FAIL basic_hold: got %b want 0", HOLD); end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start(16'd257);
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL over_done: got %b want 1", DONE); end
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL over_err: got %b want 1", ERR); end
    repeat (4) @(negedge CLK);
    total++; if (wr_pc.size() !== 0) begin bad++; $display("FAIL over_nwr: got %0d want 0", wr_pc.size()); end
    total++; if (hold_seen !== 1'b0) begin bad++; $display("FAIL over_hold: got %b want 0", hold_seen); end
  endtask

  task automatic test_zero();
    clear_log();
    pulse_start(16'd0);
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", DONE); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL zero_err: got %b want 0", ERR); end
    repeat (4) @(negedge CLK);
    total++; if (wr_pc.size() !== 0) begin bad++; $display("FAIL zero_nwr: got %0d want 0", wr_pc.size()); end
    total++; if (hold_seen !== 1'b0) begin bad++; $display("FAIL zero_hold: got %b want 0", hold_seen); end
  endtask

  task automatic test_max_count();
    pulse_start(16'd256);
    total++; if (HOLD !== 1'b1) begin bad++; $display("FAIL max_hold: got %b want 1", HOLD); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL max_done: got %b want 0", DONE); end
    total++; if (BYTE_READY !== 1'b1) begin bad++; $display("FAIL max_ready: got %b want 1", BYTE_READY); end
    #2 RST = 1'b0;
    #1;
    total++; if (HOLD !== 1'b0) begin bad++; $display("FAIL max_rst_hold: got %b want 0", HOLD); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_gap();
    clear_log();
    pulse_start(16'd1);
    send_word(32'hDEAD_BEEF, 1'b1);
    if (ChkEn) send_word(32'hDEAD_BEEF, 1'b1);
    wait_done();
    total++; if (wr_pc.size() !== 1) begin bad++; $display("FAIL gap_nwr: got %0d want 1", wr_pc.size()); end
    total++; if (wr_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL gap_word: got %h want deadbeef", wr_data[0]); end
    total++; if (wr_pc[0] !== 32'h0) begin bad++; $display("FAIL gap_pc: got %h want 0", wr_pc[0]); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL gap_err: got %b want 0", ERR); end
  endtask

  task automatic test_start_ignored();
    clear_log();
    pulse_start(16'd2);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    BYTE_VALID = 1'b0;
    pulse_start(16'd1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    BYTE_VALID = 1'b0;
    if (ChkEn) send_word(32'h6688_AACC, 1'b0);
    BYTE_VALID = 1'b0;
    wait_done();
    total++; if (wr_pc.size() !== 2) begin bad++; $display("FAIL ign_nwr: got %0d want 2", wr_pc.size()); end
    total++; if (wr_data[0] !== 32'h1122_3344) begin bad++; $display("FAIL ign_w0: got %h want 11223344", wr_data[0]); end
    total++; if (wr_data[1] !== 32'h5566_7788) begin bad++; $display("FAIL ign_w1: got %h want 55667788", wr_data[1]); end
    total++; if (wr_pc[1] !== 32'h4) begin bad++; $display("FAIL ign_pc1: got %h want 4", wr_pc[1]); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL ign_err: got %b want 0", ERR); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start(16'd3);
    send_word(32'hA1A2_A3A4, 1'b0);
    send_word(32'hB1B2_B3B4, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    BYTE_VALID = 1'b0;
    total++; if (wr_pc.size() !== 2) begin bad++; $display("FAIL mid_pre_nwr: got %0d want 2", wr_pc.size()); end
    #2 RST = 1'b0;
    #1;
    test_reset();
    @(negedge CLK);
    RST = 1'b1;
    BYTE_VALID = 1'b1;
    BYTE_IN = 8'hC3;
    repeat (10) @(negedge CLK);
    BYTE_VALID = 1'b0;
    total++; if (wr_pc.size() !== 2) begin bad++; $display("FAIL mid_nwr: got %0d want 2", wr_pc.size()); end
    total++; if (HOLD !== 1'b0) begin bad++; $display("FAIL mid_hold: got %b want 0", HOLD); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", DONE); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int t = 0; t < 2; t++) begin
      clear_log();
      pulse_start(16'd2);
      send_word(32'h1, 1'b0);
      send_word(32'h2, 1'b0);
      BYTE_VALID = 1'b0;
      total++; if (wr_pc.size() !== 2) begin bad++; $display("FAIL chk_nwr%0d: got %0d want 2", t, wr_pc.size()); end
      send_word((t == 0) ? 32'h3 : 32'h4, 1'b0);
      BYTE_VALID = 1'b0;
      wait_done();
      total++; if (wr_pc.size() !== 2) begin bad++; $display("FAIL chk_nowr%0d: got %0d want 2", t, wr_pc.size()); end
      total++; if (ERR !== (t == 1)) begin bad++; $display("FAIL chk_err%0d: got %b want %0d", t, ERR, t); end
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0; cyc = 0;
    RST = 1'b0; START = 1'b0; WORD_COUNT = 16'd0; BYTE_IN = 8'd0; BYTE_VALID = 1'b0;
    hold_seen = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset();
    RST = 1'b1;
    @(negedge CLK);
    test_basic();
    test_oversize();
    test_zero();
    test_max_count();
    test_gap();
    test_start_ignored();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
